// File: rtl/mips_control_register_scoreboard_pkg.sv
// Shared types and helpers for the Mips register-hazard scoreboard.
package mips_control_register_scoreboard_pkg;

    // Where a register write's data comes from; code 3 is illegal and behaves like Memory
    typedef enum logic [1:0] {
        SRC_ALU     = 2'd0,
        SRC_MEMORY  = 2'd1,
        SRC_PC      = 2'd2,
        SRC_ILLEGAL = 2'd3
    } write_source_e;

    // Forward-select value meaning "read the register file"
    localparam int SELECT_REGFILE = 0;

    // Entry address field is sized for the widest supported register address
    localparam int MAX_ADDR_WIDTH = 8;

    typedef struct packed {
        logic                      valid;
        logic [MAX_ADDR_WIDTH-1:0] addr;
        write_source_e             source;
    } entry_t;

    function automatic int sel_width(input int stages);
        return $clog2(stages + 1);
    endfunction

    function automatic logic is_memory_source(input write_source_e source);
        return (source == SRC_MEMORY) || (source == SRC_ILLEGAL);
    endfunction

endpackage

// File: rtl/mips_control_register_scoreboard_if.sv
// Issue-side bus between the register control decode and the scoreboard.
interface mips_control_register_scoreboard_if
    import mips_control_register_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int STAGES     = 3,
    parameter int READ_PORTS = 2
);
    localparam int SEL_WIDTH = sel_width(STAGES);

    logic                           issueValid;
    logic                           issueWriteEnable;
    logic [ADDR_WIDTH-1:0]          issueWriteAddr;
    logic [1:0]                     issueWriteSource;
    logic [READ_PORTS*ADDR_WIDTH-1:0] readAddr;
    logic [READ_PORTS-1:0]          readUse;
    logic                           flush;
    logic                           freeze;
    logic                           stall;
    logic [READ_PORTS*SEL_WIDTH-1:0] forwardSelect;
    logic [SEL_WIDTH-1:0]           inFlight;

    modport master (
        output issueValid, issueWriteEnable, issueWriteAddr, issueWriteSource,
        output readAddr, readUse, flush, freeze,
        input  stall, forwardSelect, inFlight
    );

    modport slave (
        input  issueValid, issueWriteEnable, issueWriteAddr, issueWriteSource,
        input  readAddr, readUse, flush, freeze,
        output stall, forwardSelect, inFlight
    );

endinterface

// File: rtl/mips_control_register_scoreboard_match.sv
// Youngest-producer match and readiness check for a single read port.
module mips_control_register_scoreboard_match
    import mips_control_register_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH      = 5,
    parameter int STAGES          = 3,
    parameter int MEM_READY_STAGE = 2,
    parameter int SEL_WIDTH       = 2
)
(
    input  entry_t [STAGES:1]      stages,
    input  logic [ADDR_WIDTH-1:0]  read_addr,
    input  logic                   read_use,
    output logic [SEL_WIDTH-1:0]   select,
    output logic                   not_ready
);

    // Walk oldest to youngest so the youngest matching stage is the last to assign
    always_comb begin
        select    = SEL_WIDTH'(SELECT_REGFILE);
        not_ready = 1'b0;
        if (read_use && (read_addr != '0)) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (stages[k].valid && (stages[k].addr == MAX_ADDR_WIDTH'(read_addr))) begin
                    select    = SEL_WIDTH'(k);
                    not_ready = is_memory_source(stages[k].source) && (k < MEM_READY_STAGE);
                end
            end
        end
    end

endmodule

// File: rtl/mips_control_register_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight writes, forwards and stalls on load-use.
module mips_control_register_scoreboard
    import mips_control_register_scoreboard_pkg::*;
#(
    parameter int ADDR_WIDTH      = 5,
    parameter int STAGES          = 3,
    parameter int READ_PORTS      = 2,
    parameter int MEM_READY_STAGE = 2
)
(
    input  logic                               clock,
    input  logic                               reset,
    mips_control_register_scoreboard_if.slave  bus
);
    localparam int SEL_WIDTH = sel_width(STAGES);

    entry_t [STAGES:1]      stages_q;
    entry_t                 issue_entry;
    logic                   load_bubble;
    logic [READ_PORTS-1:0]  port_not_ready;
    logic [SEL_WIDTH-1:0]   port_select [READ_PORTS];
    logic [SEL_WIDTH-1:0]   valid_count;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        mips_control_register_scoreboard_match #(
            .ADDR_WIDTH      (ADDR_WIDTH),
            .STAGES          (STAGES),
            .MEM_READY_STAGE (MEM_READY_STAGE),
            .SEL_WIDTH       (SEL_WIDTH)
        ) u_match (
            .stages    (stages_q),
            .read_addr (bus.readAddr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .read_use  (bus.readUse[p] && bus.issueValid && !reset),
            .select    (port_select[p]),
            .not_ready (port_not_ready[p])
        );
    end

    // Pack per-port selects onto the bus; they stay live during freeze
    always_comb begin
        bus.forwardSelect = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            bus.forwardSelect[p*SEL_WIDTH +: SEL_WIDTH] = port_select[p];
        end
    end

    // Flush and freeze both suppress the stall; register 0 never becomes a valid entry
    always_comb begin
        bus.stall          = (|port_not_ready) && bus.issueValid && !bus.flush && !bus.freeze && !reset;
        load_bubble        = bus.stall || bus.flush || !bus.issueValid;
        issue_entry        = '0;
        issue_entry.valid  = bus.issueWriteEnable && (bus.issueWriteAddr != '0);
        issue_entry.addr   = MAX_ADDR_WIDTH'(bus.issueWriteAddr);
        issue_entry.source = write_source_e'(bus.issueWriteSource);
    end

    // Stage pipeline: hold on freeze, otherwise shift and retire the oldest entry
    always_ff @(posedge clock) begin
        if (reset) begin
            stages_q <= '0;
        end else if (!bus.freeze) begin
            stages_q[1] <= load_bubble ? entry_t'('0) : issue_entry;
            for (int k = 2; k <= STAGES; k++) begin
                stages_q[k] <= stages_q[k-1];
            end
        end
    end

    // Count valid entries from the registered stages, forced to zero under reset
    always_comb begin
        valid_count = '0;
        for (int k = 1; k <= STAGES; k++) begin
            if (stages_q[k].valid) begin
                valid_count = valid_count + SEL_WIDTH'(1);
            end
        end
        bus.inFlight = reset ? '0 : valid_count;
    end

endmodule

// File: tb/tb_mips_control_register_scoreboard.sv
// Directed testbench for the Mips register-hazard scoreboard (default parameters).
module tb_mips_control_register_scoreboard;

    logic clock = 1'b0;
    logic reset;
    int   testCount = 0;
    int   failCount = 0;

    mips_control_register_scoreboard_if #(
        .ADDR_WIDTH (5),
        .STAGES     (3),
        .READ_PORTS (2)
    ) bus ();

    mips_control_register_scoreboard #(
        .ADDR_WIDTH      (5),
        .STAGES          (3),
        .READ_PORTS      (2),
        .MEM_READY_STAGE (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Drive one issue-cycle's worth of inputs and let the combinational outputs settle
    task automatic applyStimulus(input logic valid, input logic we, input logic [4:0] waddr,
                                 input logic [1:0] src, input logic [4:0] ra0, input logic use0,
                                 input logic [4:0] ra1, input logic use1,
                                 input logic fl, input logic fr);
        bus.issueValid       = valid;
        bus.issueWriteEnable = we;
        bus.issueWriteAddr   = waddr;
        bus.issueWriteSource = src;
        bus.readAddr         = {ra1, ra0};
        bus.readUse          = {use1, use0};
        bus.flush            = fl;
        bus.freeze           = fr;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clockTick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [1:0] sel0();
        return bus.forwardSelect[1:0];
    endfunction

    function automatic logic [1:0] sel1();
        return bus.forwardSelect[3:2];
    endfunction

    initial begin
        // Reset state
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        clockTick();
        clockTick();
        checkOutput("reset_stall", 32'(bus.stall), 0);
        checkOutput("reset_sel", 32'(bus.forwardSelect), 0);
        checkOutput("reset_inflight", 32'(bus.inFlight), 0);
        reset = 1'b0;
        idle();
        checkOutput("post_reset_inflight", 32'(bus.inFlight), 0);

        // Alu back-to-back, then ageing through stages 2 and 3 until retirement
        applyStimulus(1'b1, 1'b1, 5'd8, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("alu_b2b_stall", 32'(bus.stall), 0);
        checkOutput("alu_b2b_sel", 32'(sel0()), 1);
        checkOutput("alu_b2b_inflight", 32'(bus.inFlight), 1);
        clockTick();
        checkOutput("alu_gap_sel", 32'(sel0()), 2);
        clockTick();
        checkOutput("alu_oldest_sel", 32'(sel0()), 3);
        clockTick();
        checkOutput("alu_retired_sel", 32'(sel0()), 0);
        checkOutput("alu_retired_inflight", 32'(bus.inFlight), 0);

        // Load-use on port 1 stalls exactly one cycle
        applyStimulus(1'b1, 1'b1, 5'd9, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        checkOutput("load_use_stall", 32'(bus.stall), 1);
        checkOutput("load_use_sel", 32'(sel1()), 1);
        clockTick();
        checkOutput("load_use_release_stall", 32'(bus.stall), 0);
        checkOutput("load_use_release_sel", 32'(sel1()), 2);
        checkOutput("load_use_inflight", 32'(bus.inFlight), 1);
        clockTick();
        idle();
        clockTick();
        checkOutput("load_use_drain", 32'(bus.inFlight), 0);

        // Youngest producer wins even when an older one is ready
        applyStimulus(1'b1, 1'b1, 5'd4, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b1, 5'd4, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("youngest_stall", 32'(bus.stall), 1);
        checkOutput("youngest_sel", 32'(sel0()), 1);
        checkOutput("youngest_inflight", 32'(bus.inFlight), 2);
        clockTick();
        checkOutput("youngest_release_sel", 32'(sel0()), 2);
        checkOutput("youngest_release_stall", 32'(bus.stall), 0);
        clockTick();
        idle();
        clockTick();

        // Register 0 never tracked; readUse=0 masks a real hazard
        applyStimulus(1'b1, 1'b1, 5'd0, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("r0_inflight", 32'(bus.inFlight), 0);
        checkOutput("r0_sel", 32'(bus.forwardSelect), 0);
        applyStimulus(1'b1, 1'b1, 5'd6, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("nouse_sel", 32'(sel0()), 0);
        checkOutput("nouse_stall", 32'(bus.stall), 0);
        clockTick();
        idle();
        clockTick();
        clockTick();

        // Illegal source code behaves as Memory
        applyStimulus(1'b1, 1'b1, 5'd13, 2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("illegal_src_stall", 32'(bus.stall), 1);
        idle();
        clockTick();
        clockTick();
        clockTick();

        // Self read compares against older entries only
        applyStimulus(1'b1, 1'b1, 5'd12, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b1, 5'd12, 2'd1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("self_read_sel", 32'(sel0()), 1);
        checkOutput("self_read_stall", 32'(bus.stall), 0);
        clockTick();
        idle();
        checkOutput("self_read_inflight", 32'(bus.inFlight), 2);
        clockTick();
        clockTick();
        clockTick();

        // Flushed write leaves no entry; flush beats a pending stall
        applyStimulus(1'b1, 1'b1, 5'd5, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_sel", 32'(sel0()), 0);
        checkOutput("flush_inflight", 32'(bus.inFlight), 0);
        applyStimulus(1'b1, 1'b1, 5'd7, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_vs_stall", 32'(bus.stall), 0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_bubble_sel", 32'(sel0()), 2);
        idle();
        clockTick();
        clockTick();

        // Freeze holds a Memory entry in stage 1 for three cycles without stalling
        applyStimulus(1'b1, 1'b1, 5'd10, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("freeze_stall_%0d", i), 32'(bus.stall), 0);
            checkOutput($sformatf("freeze_sel_%0d", i), 32'(sel0()), 1);
            clockTick();
        end
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("unfreeze_stall", 32'(bus.stall), 1);
        clockTick();
        checkOutput("unfreeze_sel", 32'(sel0()), 2);
        clockTick();
        idle();
        clockTick();

        // Reset mid-flight discards all entries
        applyStimulus(1'b1, 1'b1, 5'd1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b1, 5'd2, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        applyStimulus(1'b1, 1'b1, 5'd3, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        clockTick();
        idle();
        checkOutput("midflight_inflight", 32'(bus.inFlight), 3);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("reset_mid_sel", 32'(bus.forwardSelect), 0);
        checkOutput("reset_mid_stall", 32'(bus.stall), 0);
        clockTick();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd0, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("after_reset_sel", 32'(bus.forwardSelect), 0);
        checkOutput("after_reset_inflight", 32'(bus.inFlight), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
